// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: transmit side of a UART.
// Accepts a byte on a ready/send handshake and shifts it out on tx as
// start bit, data LSB first, optional parity, then one or two stop bits.
// Every bit lasts CLK_DIV*OVERSAMPLE clock cycles.
module uart_tx_serializer #(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    output logic                 ready,
    output logic                 tx,
    output logic                 done
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SMP_W   = $clog2(OVERSAMPLE);
    localparam int BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BIT_W   = $clog2(BIT_MAX);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic [SMP_W-1:0]     smp_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;

    logic tick;
    logic bit_end;
    logic frame_end;
    logic accept;

    // Bit boundaries are decoded from the counters: a bit ends on the tick
    // that completes its last oversample slot.
    assign tick      = (div_cnt == DIV_LAST);
    assign bit_end   = tick && (smp_cnt == SMP_LAST);
    assign frame_end = (state == STOP) && (bit_cnt == STOP_LAST) && bit_end;

    // ready/done are decoded purely from registered state (no input-to-output
    // path), so they are valid during exactly the final cycle of the frame
    // and allow a zero-gap restart on that edge.
    assign done   = frame_end;
    assign ready  = (state == IDLE) || frame_end;
    assign accept = send && ready;

    // Frame sequencer: bit timing counters, shift register and the tx pin.
    always_ff @(posedge clk) begin
        // NOTE: all state here is updated with non-blocking assignments, so
        // later assignments in this block (the accept override below) win
        // cleanly and every read sees the pre-edge value.
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            smp_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            if (state != IDLE) begin
                if (tick) begin
                    div_cnt <= '0;
                    smp_cnt <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        tx <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase

            // Accepting a byte restarts every counter; this also covers the
            // back-to-back case where the last stop bit hands straight over.
            // Parity is taken from the byte as latched on this edge.
            if (accept) begin
                state      <= START;
                div_cnt    <= '0;
                smp_cnt    <= '0;
                bit_cnt    <= '0;
                shreg      <= data_in;
                parity_bit <= (^data_in) ^ (PARITY_ODD != 0);
                tx         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: four instances with different baud,
// parity and stop-bit settings, checked cycle by cycle against a frame model
// built from the byte value (start, data LSB first, parity, stops).
module tb_uart_tx_serializer;

    localparam int CLK_PERIOD = 10;
    localparam int N_INST     = 4;

    // Per-instance configuration.
    localparam int CD [N_INST] = '{2, 1, 3, 1};
    localparam int OS [N_INST] = '{16, 16, 4, 2};
    localparam int PE [N_INST] = '{0, 1, 1, 0};
    localparam int PO [N_INST] = '{0, 0, 1, 0};
    localparam int SB [N_INST] = '{1, 1, 1, 2};

    logic              clk;
    logic              rst;
    logic [7:0]        data_in;
    logic [N_INST-1:0] send_v;
    logic [N_INST-1:0] tx_w;
    logic [N_INST-1:0] ready_w;
    logic [N_INST-1:0] done_w;

    int tests_run;
    int tests_failed;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        uart_tx_serializer #(
            .CLK_DIV   (CD[g]),
            .OVERSAMPLE(OS[g]),
            .DATA_BITS (8),
            .PARITY_EN (PE[g]),
            .PARITY_ODD(PO[g]),
            .STOP_BITS (SB[g])
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .data_in(data_in),
            .send   (send_v[g]),
            .ready  (ready_w[g]),
            .tx     (tx_w[g]),
            .done   (done_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #(CLK_PERIOD / 2) clk = ~clk;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int bit_period(input int i);
        return CD[i] * OS[i];
    endfunction

    function automatic int frame_bits(input int i);
        return 1 + 8 + PE[i] + SB[i];
    endfunction

    // Expected line level of frame bit k (k = 0 is the start bit).
    function automatic logic exp_bit(input int i, input logic [7:0] b, input int k);
        int ones;
        if (k == 0) return 1'b0;
        if (k <= 8) return ((b >> (k - 1)) & 8'd1) != 0;
        if (PE[i] != 0 && k == 9) begin
            ones = $countones(b);
            return ((ones % 2) == 1) ^ (PO[i] != 0);
        end
        return 1'b1;
    endfunction

    // ---------------- helpers ----------------
    // Present a byte while the instance should be ready; the following posedge
    // is the accept edge E0. Returns just after E0.
    task automatic send_byte(input int inst, input logic [7:0] b, input bit hold);
        @(negedge clk);
        tests_run++;
        if (ready_w[inst] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_before_send inst%0d: got %b want 1", inst, ready_w[inst]);
        end
        data_in      = b;
        send_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) send_v[inst] = 1'b0;
    endtask

    // Watch cycles E0+1 .. E0+F*B of a frame and compare tx, ready and done
    // against the model. Optionally pulse send mid-frame at cycle pulse_at.
    task automatic observe_frame(input int inst, input logic [7:0] b, input int pulse_at,
                                 output longint done_t);
        int   bp, total;
        int   bad_tx, bad_rdy, bad_done;
        int   first_tx;
        logic got_tx, want_tx, last;
        bp       = bit_period(inst);
        total    = frame_bits(inst) * bp;
        bad_tx   = 0;
        bad_rdy  = 0;
        bad_done = 0;
        first_tx = 0;
        got_tx   = 1'b0;
        want_tx  = 1'b0;
        done_t   = -1;
        for (int m = 1; m <= total; m++) begin
            @(negedge clk);
            last = (m == total);
            if (tx_w[inst] !== exp_bit(inst, b, (m - 1) / bp)) begin
                if (bad_tx == 0) begin
                    first_tx = m;
                    got_tx   = tx_w[inst];
                    want_tx  = exp_bit(inst, b, (m - 1) / bp);
                end
                bad_tx++;
            end
            if (ready_w[inst] !== last) bad_rdy++;
            if (done_w[inst] !== last) bad_done++;
            if (done_w[inst] === 1'b1) done_t = $time;
            if (pulse_at > 0 && m == pulse_at) begin
                data_in      = 8'h3C;
                send_v[inst] = 1'b1;
            end else if (pulse_at > 0 && m == pulse_at + 1) begin
                send_v[inst] = 1'b0;
            end
        end
        tests_run += 3;
        if (bad_tx != 0) begin
            tests_failed++;
            $display("FAIL frame_tx inst%0d byte=%02h: %0d bad cycles, first at E0+%0d got %b want %b",
                     inst, b, bad_tx, first_tx, got_tx, want_tx);
        end
        if (bad_rdy != 0) begin
            tests_failed++;
            $display("FAIL frame_ready inst%0d byte=%02h: %0d cycles wrong, want low until E0+%0d",
                     inst, b, bad_rdy, total);
        end
        if (bad_done != 0) begin
            tests_failed++;
            $display("FAIL frame_done inst%0d byte=%02h: %0d cycles wrong, want single pulse at E0+%0d",
                     inst, b, bad_done, total);
        end
    endtask

    task automatic idle_check(input int inst, input string name);
        @(negedge clk);
        tests_run++;
        if ({tx_w[inst], ready_w[inst], done_w[inst]} !== 3'b110) begin
            tests_failed++;
            $display("FAIL %s inst%0d: tx/ready/done got %b%b%b want 110",
                     name, inst, tx_w[inst], ready_w[inst], done_w[inst]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int bad;
        bad = 0;
        @(posedge clk);
        #1;
        send_v  = '1;
        data_in = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (tx_w !== '1 || ready_w !== '1 || done_w !== '0) bad++;
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        send_v = '0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL reset_hold: %0d cycles with tx/ready/done off their reset values, want 0", bad);
        end
        for (int i = 0; i < N_INST; i++) idle_check(i, "after_reset");
    endtask

    task automatic test_basic();
        longint t;
        logic [7:0] b;
        send_byte(0, 8'hA5, 1'b0);
        observe_frame(0, 8'hA5, 0, t);
        idle_check(0, "basic_idle");
        for (int r = 0; r < 2; r++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(0, b, 1'b0);
            observe_frame(0, b, 0, t);
        end
        idle_check(0, "basic_random_idle");
    endtask

    task automatic test_parity();
        longint t;
        logic [7:0] b;
        for (int i = 1; i <= 2; i++) begin
            send_byte(i, 8'h07, 1'b0);
            observe_frame(i, 8'h07, 0, t);
            idle_check(i, "parity_idle");
            for (int r = 0; r < 2; r++) begin
                b = 8'($urandom_range(0, 255));
                send_byte(i, b, 1'b0);
                observe_frame(i, b, 0, t);
            end
        end
    endtask

    task automatic test_back_to_back();
        longint t1, t2;
        send_byte(0, 8'h00, 1'b1);
        data_in = 8'hFF;          // new value must not disturb the running frame
        observe_frame(0, 8'h00, 0, t1);
        @(posedge clk);           // second accept edge, send still high
        #1;
        send_v[0] = 1'b0;
        observe_frame(0, 8'hFF, 0, t2);
        tests_run++;
        if (t2 - t1 != longint'(frame_bits(0) * bit_period(0) * CLK_PERIOD)) begin
            tests_failed++;
            $display("FAIL b2b_done_gap: got %0d ns want %0d ns", t2 - t1,
                     frame_bits(0) * bit_period(0) * CLK_PERIOD);
        end
        idle_check(0, "b2b_idle");
    endtask

    task automatic test_busy_abort();
        longint t;
        int bp, bad;
        bp = bit_period(0);
        send_byte(0, 8'h81, 1'b0);
        observe_frame(0, 8'h81, 3 * bp + 3, t);
        idle_check(0, "busy_idle");

        send_byte(0, 8'h81, 1'b0);
        repeat (4 * bp + bp / 2) @(negedge clk);
        tests_run++;
        if (tx_w[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_midframe_tx: got %b want 0", tx_w[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_check(0, "abort_next_edge");
        bad = 0;
        for (int c = 0; c < 12 * bp; c++) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: %0d cycles with done=1 or tx=0, want 0", bad);
        end
    endtask

    task automatic test_two_stop();
        longint t;
        logic [7:0] b;
        send_byte(3, 8'h55, 1'b0);
        observe_frame(3, 8'h55, 0, t);
        idle_check(3, "two_stop_idle");
        for (int r = 0; r < 3; r++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(3, b, 1'b0);
            observe_frame(3, b, 0, t);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        send_v       = '0;
        data_in      = 8'h00;

        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_busy_abort();
        test_two_stop();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
